// File: rtl/cpri_tx_arb.sv
// cpri_tx_arb
// Packet-level round-robin arbiter that shares the CPRI TX packager write port
// between NUM_SRC packet sources. One whole packet is granted at a time, and a
// grant is only issued while the packager reports at least MIN_FREE free slots.
// Each packet's length is checked against the type field carried in word 2.
// A packet that stalls for TIMEOUT cycles is aborted.
//
// Ports
//   wr_clk, wr_rst   clock, synchronous active-high reset
//   i_src_req        per-source packet request (level, held until granted)
//   i_src_vld/sop/eop per-source word qualifiers
//   i_src_data       per-source 64-bit data, source k at [64k+63:64k]
//   o_src_gnt        one-hot registered grant
//   i_free_size      free packet slots reported by the packager
//   o_vld/sop/eop    registered muxed stream to the packager
//   o_data           registered muxed data
//   o_gnt_id         index of the current or last granted source
//   o_busy           high while a packet or the post-packet gap is in progress
//   o_err_len        one-cycle pulse with o_eop when the length/type check fails
//   o_err_timeout    one-cycle pulse when a packet is aborted by the stall timer
module cpri_tx_arb #(
  parameter int NUM_SRC    = 4,
  parameter int MIN_FREE   = 1,
  parameter int GAP_CYCLES = 3,
  parameter int TIMEOUT    = 255,
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    wr_clk,
  input  logic                    wr_rst,
  input  logic [NUM_SRC-1:0]      i_src_req,
  input  logic [NUM_SRC-1:0]      i_src_vld,
  input  logic [NUM_SRC-1:0]      i_src_sop,
  input  logic [NUM_SRC-1:0]      i_src_eop,
  input  logic [64*NUM_SRC-1:0]   i_src_data,
  output logic [NUM_SRC-1:0]      o_src_gnt,
  input  logic [3:0]              i_free_size,
  output logic                    o_vld,
  output logic                    o_sop,
  output logic                    o_eop,
  output logic [63:0]             o_data,
  output logic [GW-1:0]           o_gnt_id,
  output logic                    o_busy,
  output logic                    o_err_len,
  output logic                    o_err_timeout
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [6:0]    wcnt;
  logic [3:0]    pkt_type;
  logic          sop_err;
  logic [7:0]    stall_cnt;
  // Gap counter is 8 bits wide, so GAP_CYCLES is limited to 255.
  logic [7:0]    gap_cnt;

  logic [63:0]   src_data [NUM_SRC];
  logic [GW-1:0] win;
  logic          win_found;
  logic          sel_vld;
  logic          sel_sop;
  logic          sel_eop;
  logic [63:0]   sel_data;
  logic [3:0]    cur_type;
  logic [7:0]    exp_len;
  logic          len_bad;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_data[k] = i_src_data[k*64 +: 64];
    end
  end

  // Round-robin search starting one past the last winner, so the source that
  // was just served has the lowest priority.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    idx       = 0;
    cand      = '0;
    win       = '0;
    win_found = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx  = (int'(ptr) + i) % NUM_SRC;
      cand = GW'(idx);
      if (!win_found && i_src_req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // Only the granted source reaches the output mux; everyone else is ignored.
  always_comb begin
    sel_vld  = (state == XFER) && i_src_vld[o_gnt_id];
    sel_sop  = i_src_sop[o_gnt_id];
    sel_eop  = i_src_eop[o_gnt_id];
    sel_data = src_data[o_gnt_id];
  end

  // The type may arrive on the very word that carries eop (a 3-word packet),
  // so word 2's type is taken straight from the bus in that case.
  always_comb begin
    cur_type = (wcnt == 7'd2) ? sel_data[7:4] : pkt_type;
    case (cur_type)
      4'd1:    exp_len = 8'd56;
      4'd2:    exp_len = 8'd38;
      4'd3:    exp_len = 8'd86;
      4'd4:    exp_len = 8'd62;
      default: exp_len = 8'd0;
    endcase
    len_bad = (exp_len == 8'd0)
           || (({1'b0, wcnt} + 8'd1) != exp_len)
           || sop_err
           || (sel_sop && (wcnt != 7'd0));
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state         <= IDLE;
      ptr           <= GW'(NUM_SRC - 1);
      wcnt          <= '0;
      pkt_type      <= '0;
      sop_err       <= 1'b0;
      stall_cnt     <= '0;
      gap_cnt       <= '0;
      o_src_gnt     <= '0;
      o_vld         <= 1'b0;
      o_sop         <= 1'b0;
      o_eop         <= 1'b0;
      o_data        <= '0;
      o_gnt_id      <= '0;
      o_busy        <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      o_vld         <= 1'b0;
      o_sop         <= 1'b0;
      o_eop         <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (win_found && (int'(i_free_size) >= MIN_FREE)) begin
            ptr       <= win;
            o_gnt_id  <= win;
            o_src_gnt <= NUM_SRC'(1) << win;
            o_busy    <= 1'b1;
            wcnt      <= '0;
            pkt_type  <= '0;
            sop_err   <= 1'b0;
            stall_cnt <= '0;
            state     <= XFER;
          end
        end

        XFER: begin
          if (sel_vld) begin
            o_vld     <= 1'b1;
            o_sop     <= sel_sop;
            o_eop     <= sel_eop;
            o_data    <= sel_data;
            stall_cnt <= '0;
            if (wcnt != 7'd127) begin
              wcnt <= wcnt + 7'd1;
            end
            if (wcnt == 7'd2) begin
              pkt_type <= sel_data[7:4];
            end
            // A misplaced sop is passed through but poisons this packet's eop.
            if (sel_sop && (wcnt != 7'd0)) begin
              sop_err <= 1'b1;
            end
            if (sel_eop) begin
              o_err_len <= len_bad;
              o_src_gnt <= '0;
              gap_cnt   <= '0;
              state     <= GAP;
            end
          end else if (stall_cnt == 8'(TIMEOUT)) begin
            // Abort without an eop; the packager is realigned by wr_rst.
            o_err_timeout <= 1'b1;
            o_src_gnt     <= '0;
            gap_cnt       <= '0;
            state         <= GAP;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end

        GAP: begin
          // Gives the packager time to update i_free_size before re-arbitrating.
          if ((int'(gap_cnt) + 1) >= GAP_CYCLES) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cpri_tx_arb.md
# cpri_tx_arb

Packet-level round-robin arbiter and sequencer placed in front of the CPRI TX packager, in the packager's write-clock domain. It shares the single packager write port between up to NUM_SRC packet sources: power, data, data+bf-12RB and data+bf-6RB. It grants one whole packet at a time, and only while the packager reports free buffer slots. It also checks each packet's length against its type field and aborts stalled packets.

## Interface
Parameters:
- NUM_SRC, 4, number of requesters (2..8); GW = clog2(NUM_SRC)
- MIN_FREE, 1, minimum i_free_size needed to issue a grant
- GAP_CYCLES, 3, idle cycles after each packet before the next grant (covers free-size update lag)
- TIMEOUT, 255, maximum consecutive cycles without i_src_vld inside a granted packet (8-bit counter)

Ports:
- wr_clk  in  1  single clock
- wr_rst  in  1  synchronous, active-high reset
- i_src_req  in  NUM_SRC  per-source packet request; level, held until granted
- i_src_vld  in  NUM_SRC  per-source word valid
- i_src_sop  in  NUM_SRC  per-source start of packet
- i_src_eop  in  NUM_SRC  per-source end of packet
- i_src_data  in  64*NUM_SRC  per-source data; source k uses bits [64k+63:64k]
- o_src_gnt  out  NUM_SRC  one-hot grant, registered
- i_free_size  in  4  free packet slots reported by the packager
- o_vld / o_sop / o_eop  out  1 each  muxed, registered stream to the packager
- o_data  out  64  muxed, registered data
- o_gnt_id  out  GW  index of the current or last granted source
- o_busy  out  1  high in XFER and GAP
- o_err_len  out  1  one-cycle pulse: packet length does not match its type
- o_err_timeout  out  1  one-cycle pulse: packet aborted by the stall timeout

## Operation
- FSM has three states: IDLE, XFER, GAP. Reset state is IDLE.
- IDLE:
  - Grant is issued when (|i_src_req) and i_free_size >= MIN_FREE.
  - Round-robin selection: search starts at ptr+1 mod NUM_SRC. The winner is latched into ptr and o_gnt_id, its o_src_gnt bit is set, and the FSM moves to XFER.
  - After reset ptr = NUM_SRC-1, so source 0 has first priority.
- XFER:
  - Only the granted source's vld/sop/eop/data are forwarded. Other sources' vld is ignored (their words are dropped).
  - Word counter wcnt (7 bits, saturates at 127) increments on each forwarded vld. It resets to 0 on grant.
  - The type field is captured from data[7:4] of the word where wcnt==2.
  - Expected length per type: 1 -> 56, 2 -> 38, 3 -> 86, 4 -> 62 words. Any other type is always an error.
  - On a forwarded vld&eop:
    - o_err_len pulses if (wcnt+1) differs from the expected length, or the type is invalid.
    - o_src_gnt clears and the FSM moves to GAP.
  - A granted sop with wcnt != 0 is forwarded unchanged and forces o_err_len at that packet's eop.
  - Stall counter: resets on every forwarded vld and increments otherwise. If it reaches TIMEOUT:
    - o_err_timeout pulses and o_src_gnt clears; no eop is emitted.
    - The FSM moves to GAP.
    - Packager realignment is by wr_rst (system-level).
- GAP: counts GAP_CYCLES cycles with no grant, then returns to IDLE. It is entered from both the eop and the timeout paths.
- o_gnt_id keeps its value after a packet ends.
- Reset mid-operation:
  - All outputs go to 0: o_src_gnt, o_vld, o_sop, o_eop, o_data, o_busy, o_err_len, o_err_timeout, o_gnt_id.
  - ptr = NUM_SRC-1 and the counters clear.
  - Any partial packet is abandoned; no eop is generated.

## Timing
- Grant latency: request and space seen in IDLE at cycle t -> o_src_gnt high at t+1.
- Sources may drive vld from the cycle where they see gnt high. Words presented while gnt is low are ignored.
- Datapath latency: a granted word at cycle t appears on o_vld/o_data at t+1.
- Eop accepted at t:
  - o_eop at t+1; o_src_gnt low at t+1.
  - The next grant is no earlier than t+1+GAP_CYCLES+1.
  - Source vld at t+1 is ignored.
- o_err_len is asserted in the same cycle as o_eop. o_err_timeout is asserted the cycle after the counter reaches TIMEOUT.
- Space is checked only at grant time. A drop in i_free_size during XFER does not stall the packet.
- Simultaneous requests: exactly one grant. A requester that was just granted has lowest priority in the next arbitration.
- i_free_size < MIN_FREE: the arbiter stays in IDLE with pending requests held.

## Test plan
- Single source 0 sends a type-2 packet of 38 words with i_free_size=4 -> gnt[0] at t+1, 38 o_vld with o_eop on word 38, o_err_len=0, three GAP cycles, then IDLE.
- Sources 0..3 all request continuously, with valid-length packets -> grant order 0,1,2,3,0; no overlap between grants; o_gnt_id follows the order.
- i_free_size=0 with source 1 requesting for 20 cycles, then set to 2 -> no grant during the 20 cycles; gnt[1] one cycle after the change.
- Type-3 packet (expected 86 words) ended with eop at word 80 -> o_err_len pulse together with o_eop; the next grant proceeds normally.
- Granted source stops vld after word 10 with TIMEOUT=255 -> o_err_timeout one cycle after 255 idle cycles, gnt cleared, no o_eop, GAP, then the next requester is served.
- wr_rst asserted at word 20 of a packet -> all outputs are 0 next cycle; after release, source 0 is granted first.
